// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, one-cycle SRAM response capture, 4-deep {pc,instr} queue.
// Optional misaligned-redirect exception entry enabled with `define FETCH_ALIGN_CHECK_EN.
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int          PTR_W    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_adel
);

   localparam int DEPTH = 2**PTR_W;

   logic [31:0]      fetch_pc;
   logic [31:0]      req_pc;
   logic             inflight;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   // Credits cover both queued entries and the response still on its way back.
   logic [PTR_W+1:0] occupancy;
   logic             credit_ok;
   logic             issue;
   logic             resp_push;
   logic             push;
   logic             pop;
   logic [31:0]      push_pc;
   logic [31:0]      push_instr;

   assign occupancy = {1'b0, count} + (PTR_W+2)'(inflight);
   assign credit_ok = (occupancy < (PTR_W+2)'(DEPTH));
   assign resp_push = inflight & ~redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        halted;
   logic        adel_pend;
   logic [31:0] adel_pc;
   logic        adel_push;
   logic        adel_mem [DEPTH];

   assign issue     = resetn & ~redirect_valid & credit_ok & ~halted & ~adel_pend;
   assign adel_push = adel_pend & ~redirect_valid & credit_ok;
   assign push      = resp_push | adel_push;
   assign push_pc    = resp_push ? req_pc : adel_pc;
   assign push_instr = resp_push ? inst_sram_rdata : 32'b0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         halted    <= 1'b0;
         adel_pend <= 1'b0;
         adel_pc   <= 32'b0;
      end else if (redirect_valid) begin
         halted    <= 1'b0;
         adel_pend <= (redirect_pc[1:0] != 2'b00);
         adel_pc   <= redirect_pc;
      end else if (adel_push) begin
         adel_pend <= 1'b0;
         halted    <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         adel_mem[wr_ptr] <= ~resp_push;
   end

   assign out_adel = out_valid & adel_mem[rd_ptr];
`else
   assign issue      = resetn & ~redirect_valid & credit_ok;
   assign push       = resp_push;
   assign push_pc    = req_pc;
   assign push_instr = inst_sram_rdata;
   assign out_adel   = 1'b0;
`endif

   assign out_valid = resetn & (count != '0);
   assign pop       = out_valid & out_ready;

   assign inst_sram_en    = issue;
   assign inst_sram_wen   = 4'b0;
   assign inst_sram_addr  = fetch_pc;
   assign inst_sram_wdata = 32'b0;

   assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'b0;
   assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'b0;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         fetch_pc <= RESET_PC;
         req_pc   <= 32'b0;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
         fetch_pc <= redirect_pc;
`else
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
`endif
         inflight <= 1'b0;
      end else if (issue) begin
         fetch_pc <= fetch_pc + 32'd4;
         req_pc   <= fetch_pc;
         inflight <= 1'b1;
      end else begin
         inflight <= 1'b0;
      end
   end

   // Redirect flushes the queue even when decode takes the head in that same cycle.
   always_ff @(posedge clk) begin
      if (!resetn || redirect_valid) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end between the synchronous instruction SRAM port and the decode side of the core.
- Generates the sequential fetch PC and drives the inst SRAM request.
- Captures returning words, which arrive one cycle after the request, into a small FIFO with their PCs.
- Presents {pc, instr} to decode over a valid/ready handshake; a branch/jump redirect flushes all queued and in-flight fetches.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC of the first fetch after reset.
- PTR_W, 2, FIFO pointer width; queue depth DEPTH = 2**PTR_W entries (4).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- resetn  input  1  reset, synchronous, active-low.
- inst_sram_en  output  1  SRAM read request this cycle.
- inst_sram_wen  output  4  constant 4'b0.
- inst_sram_addr  output  32  fetch address; equals fetch_pc.
- inst_sram_wdata  output  32  constant 32'b0.
- inst_sram_rdata  input  32  read data; valid the cycle after a request.
- redirect_valid  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch target.
- out_valid  output  1  head entry valid.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_adel  output  1  head entry is a misaligned-fetch exception (see Optional Feature).

Behaviour:
- Reset (resetn low at an edge):
  - fetch_pc <= RESET_PC; count <= 0; rd_ptr/wr_ptr <= 0; inflight <= 0.
  - While resetn is low, inst_sram_en = 0, out_valid = 0, out_pc = 0, out_instr = 0, out_adel = 0.
  - Reset mid-operation discards everything, including a response that arrives the cycle after.
- Issue rule: inst_sram_en = resetn & ~redirect_valid & ((count + inflight) < DEPTH) & ~halted.
  - count is PTR_W+1 bits wide.
  - On issue: fetch_pc <= fetch_pc + 4 (wraps mod 2^32); req_pc <= fetch_pc; inflight <= 1.
  - With no issue, inflight <= 0.
- Response: when inflight = 1 and no redirect occurs this cycle, write {req_pc, inst_sram_rdata} at wr_ptr and advance wr_ptr.
  - The credit rule guarantees the FIFO never overflows; a push with the FIFO full is impossible by construction.
- Output: out_valid = (count != 0); out_pc, out_instr and out_adel come combinationally from the rd_ptr entry, and are 0 when empty.
  - Pop when out_valid & out_ready; rd_ptr advances.
  - Simultaneous push and pop leaves count unchanged.
- Latency: first request issues in the first cycle with resetn high (cycle 0); data is pushed at the end of cycle 1; out_valid = 1 in cycle 2.
  - With out_ready held high, throughput is 1 instruction/cycle after the initial 2 cycles.
- Redirect (highest priority):
  - In the redirect cycle: count <= 0, pointers <= 0, any arriving response is discarded, inflight <= 0, no request issued, fetch_pc <= redirect_pc, halted <= 0.
  - A handshake in the same cycle counts as accepted by decode; the queue is flushed regardless.
  - The first request to redirect_pc issues in the next cycle.
- Back-to-back redirects: the last one wins; no requests issue while redirect_valid is held high.
- Backpressure: with out_ready low, the FIFO fills to DEPTH and issue stops. Issue resumes in the cycle after the pop that frees a credit.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 issues no SRAM request.
  - The next cycle, it pushes one entry {redirect_pc, 32'b0, adel=1} when a credit is available, then sets halted = 1.
  - While halted, no requests issue until the next redirect or reset.
  - A RESET_PC with nonzero low bits is not supported.
- Undefined: fetch_pc <= {redirect_pc[31:2], 2'b00}; out_adel is tied to 0; halted does not exist.

Test Plan:
- Reset then out_ready = 1 -> inst_sram_addr 0xBFC00000, 0xBFC00004, ... on consecutive cycles; out_valid rises in cycle 2; out_pc/out_instr match SRAM contents in order with no gaps.
- out_ready = 0 for 10 cycles -> exactly 4 requests issued, then inst_sram_en stays 0. Raise out_ready -> entries pop in order 0xBFC00000..0xBFC0000C, and issue restarts at 0xBFC00010 the cycle after the first pop.
- Redirect to 0x80001000 while 3 entries are queued and 1 is in flight -> next cycle out_valid = 0 and inst_sram_addr = 0x80001000; no stale PC ever appears on out_pc.
- Redirect to 0x80002000 in the same cycle as an out handshake -> handshake accepted, queue empty next cycle, first new out_pc = 0x80002000.
- Reset asserted mid-stream with 2 entries queued -> next cycle out_valid = 0; after release, fetch restarts at 0xBFC00000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x80000002 -> one entry with out_pc 0x80000002, out_instr 0, out_adel 1, and no further inst_sram_en until a redirect to 0x80000004. Without the macro, the same redirect fetches 0x80000000 and out_adel stays 0.
